ysyx_25070198_mem_responder: RTL

//  Memory-side responder for the req/resp fetch and load/store protocol: accepts one request
//  per handshake and returns read data or a write acknowledgement after a fixed latency.

---
 rtl/ysyx_25070198_mem_responder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ysyx_25070198_mem_responder.sv
// Word-organised, byte-maskable memory responder: one request per req handshake,
// read data or write ack after LATENCY edges, held until the initiator takes it.
module ysyx_25070198_mem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_wen_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wmask_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [1:0]  state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; the responder holds resp_* stable while resp_valid is high and not taken.

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [31:0]    addr_q;
  logic           wen_q;
  logic [31:0]    wdata_q;
  logic [3:0]     wmask_q;
  logic           req_ready_q;
  logic           resp_valid_q;
  logic [31:0]    rdata_q;
  logic           err_q;
  logic [31:0]    mem_q [DEPTH];

  logic           acc_fire;
  logic [31:0]    acc_addr;
  logic           acc_wen;
  logic [31:0]    acc_wdata;
  logic [3:0]     acc_wmask;
  logic [31:0]    acc_off;
  logic           acc_in_range;
  logic [AW-1:0]  acc_idx;
  logic [31:0]    rdata_d;
  logic           err_d;

  // With a single-cycle latency the access uses the live request on the accept edge;
  // otherwise it uses the latched request on the edge where the countdown reaches 1.
  always_comb begin
    if (LATENCY == 1) begin
      acc_fire  = (state_q == S_IDLE) && req_valid_i;
      acc_addr  = req_addr_i;
      acc_wen   = req_wen_i;
      acc_wdata = req_wdata_i;
      acc_wmask = req_wmask_i;
    end else begin
      acc_fire  = (state_q == S_BUSY) && (cnt_q == CW'(1));
      acc_addr  = addr_q;
      acc_wen   = wen_q;
      acc_wdata = wdata_q;
      acc_wmask = wmask_q;
    end
    acc_off      = acc_addr - BASE;
    acc_in_range = acc_off < SPAN;
    acc_idx      = acc_off[AW+1:2];
    err_d        = !acc_in_range;
    rdata_d      = (acc_in_range && !acc_wen) ? mem_q[acc_idx] : 32'h0;
  end

  // Storage is deliberately not reset; the rst gate keeps an in-flight write from landing.
  always_ff @(posedge clk) begin
    if (!rst && acc_fire && acc_wen && acc_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wmask[i]) begin
          mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            addr_q      <= req_addr_i;
            wen_q       <= req_wen_i;
            wdata_q     <= req_wdata_i;
            wmask_q     <= req_wmask_i;
            req_ready_q <= 1'b0;
            if (LATENCY == 1) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              rdata_q      <= rdata_d;
              err_q        <= err_d;
            end else begin
              state_q <= S_BUSY;
              cnt_q   <= CW'(LATENCY - 1);
            end
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q - 1'b1;
          if (acc_fire) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
          end
        end
        S_RESP: begin
          if (resp_ready_i) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            rdata_q      <= '0;
            err_q        <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  assign state_o      = state_q;

endmodule
